// File: rtl/dm_ctrl.sv
// Data-memory controller for the MEM stage: byte/half/word loads and stores, range/alignment checks, store log.
// Latency: response LAT cycles after acceptance; store commits and logs on the acceptance edge.
// Backpressure: req_ready low during post-reset clear and while a request is outstanding (one at a time).
module dm_ctrl #(
  parameter int          DEPTH     = 3072,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LAT       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        init_done,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT} state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic [2:0]    lat_cnt;
  logic [31:0]   rd_hold;
  logic [1:0]    exc_hold;

  // Storage has no reset; the clear engine zeroes it one word per cycle.
  logic [31:0]   mem [DEPTH];

  logic [31:0]   off_w;
  logic [AW-1:0] idx;
  logic          out_of_range;
  logic          misaligned;
  logic [1:0]    exc;
  logic [31:0]   cur_word;
  logic [7:0]    sel_b;
  logic [15:0]   sel_h;
  logic [31:0]   load_val;
  logic [31:0]   merged;
  logic          handshake;
  logic          st_commit;
  logic          clr_we;

  // Word offset in 32-bit unsigned arithmetic; wrap-around below BASE_ADDR is caught by the compare.
  assign off_w        = (req_addr - BASE_ADDR) >> 2;
  assign idx          = off_w[AW-1:0];
  assign out_of_range = (req_addr < BASE_ADDR) || (off_w >= 32'(DEPTH));
  assign exc          = out_of_range ? 2'd2 : (misaligned ? 2'd1 : 2'd0);

  assign cur_word = mem[idx];
  assign sel_b    = cur_word[{req_addr[1:0], 3'b000} +: 8];
  assign sel_h    = cur_word[{req_addr[1], 4'b0000} +: 16];

  assign handshake = req_valid && req_ready;
  assign st_commit = handshake && req_we && (exc == 2'd0);
  assign clr_we    = (state == CLEAR);

  // Alignment check; size 3 is reported as misaligned.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Lane select plus sign/zero extension for loads.
  always_comb begin
    load_val = cur_word;
    case (req_size)
      2'd0:    load_val = {{24{sel_b[7] & ~req_unsigned}}, sel_b};
      2'd1:    load_val = {{16{sel_h[15] & ~req_unsigned}}, sel_h};
      default: load_val = cur_word;
    endcase
  end

  // Read-modify-write merge of store data into the addressed word.
  always_comb begin
    merged = cur_word;
    case (req_size)
      2'd0:    merged[{req_addr[1:0], 3'b000} +: 8]  = req_wdata[7:0];
      2'd1:    merged[{req_addr[1], 4'b0000} +: 16]  = req_wdata[15:0];
      default: merged = req_wdata;
    endcase
  end

  // Single write port shared by the clear engine and committed stores.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (st_commit) begin
      mem[idx] <= merged;
    end
  end

  // Control FSM with registered outputs: clear, accept, count latency, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      lat_cnt    <= '0;
      rd_hold    <= '0;
      exc_hold   <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_exc   <= '0;
      init_done  <= 1'b0;
      log_valid  <= 1'b0;
      log_pc     <= '0;
      log_addr   <= '0;
      log_data   <= '0;
    end else begin
      resp_valid <= 1'b0;
      log_valid  <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_idx == AW'(DEPTH - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        IDLE: begin
          if (handshake) begin
            state     <= WAIT;
            req_ready <= 1'b0;
            lat_cnt   <= '0;
            exc_hold  <= exc;
            rd_hold   <= (!req_we && exc == 2'd0) ? load_val : 32'd0;
            if (st_commit) begin
              log_valid <= 1'b1;
              log_pc    <= req_pc;
              log_addr  <= {req_addr[31:2], 2'b00};
              log_data  <= merged;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 3'(LAT - 1)) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_rdata <= rd_hold;
            resp_exc   <= exc_hold;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised data-memory controller for the MIPS CPU's MEM stage. It provides byte, half and word loads and stores with sign or zero extension, address range and alignment checking, and a valid/ready request handshake with configurable read latency. After reset it clears the whole array with an internal clear engine, one word per cycle, rather than resetting every word in parallel. Every committed store produces a registered log record for the `@PC: *addr <= data` trace.

## Interface
- `DEPTH`, 3072: memory size in 32-bit words; must be ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be word-aligned.
- `LAT`, 1: cycles from request acceptance to response; legal range 1..8.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned` input 1: zero-extend byte/half loads when 1.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `req_pc` input 32: PC of the issuing instruction, used for logging.
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and exceptions.
- `resp_exc` output 2: 0 = ok, 1 = misaligned or illegal size, 2 = out of range.
- `init_done` output 1: clear sequence finished.
- `log_valid` output 1: one-cycle pulse per committed store.
- `log_pc` output 32: PC of the committed store.
- `log_addr` output 32: word-aligned byte address of the committed store.
- `log_data` output 32: full memory word after the merge.

## Operation
- **States:**
  - CLEAR: the clear counter `clr_idx` walks 0..DEPTH-1 and writes 0 to one word per cycle. It moves to IDLE after writing word DEPTH-1.
  - IDLE: `req_ready`=1. A handshake (`req_valid`&&`req_ready`) moves to WAIT.
  - WAIT: the latency counter runs `LAT` cycles. The controller then returns to IDLE.
- **While reset is asserted:**
  - The state is CLEAR and `clr_idx`=0.
  - All outputs are 0.
  - The array contents are don't-care until the clear sequence finishes.
- **Reset mid-clear or mid-request:** the clear restarts from word 0. Any in-flight request is dropped with no response. A store already committed stays committed until it is cleared.
- **Request checks at acceptance:**
  - Word offset `off` = (`req_addr` − `BASE_ADDR`) >> 2, computed in 32-bit unsigned arithmetic.
  - Out of range when `req_addr` < `BASE_ADDR` or `off` ≥ `DEPTH`.
  - Misaligned when either:
    - `req_size`=1 and `addr[0]`≠0;
    - `req_size`=2 and `addr[1:0]`≠0.
  - `req_size`=3 is treated as misaligned.
  - When both out-of-range and misaligned apply, out-of-range wins: `resp_exc`=2.
  - A faulting store does not write the array and does not log.
- **Store merge:**
  - Byte: `wdata[7:0]` goes to lane `addr[1:0]`.
  - Half: `wdata[15:0]` goes to lanes `{addr[1],0}` and `{addr[1],1}`.
  - Word: the whole word is written.
  - Lane 0 is bits [7:0]. Other lanes are untouched.
- **Load:**
  - The word is read at acceptance and held in a response register.
  - The selected byte or half is sign-extended, or zero-extended when `req_unsigned`=1.
  - Word loads ignore `req_unsigned`.

## Timing
- **Clear:** `init_done` rises, and `req_ready` rises with it, exactly `DEPTH` rising edges after `reset` falls.
- **Handshake:** a request is accepted on edge E. `req_ready` is 0 from E until `resp_valid` has pulsed, so at most one request is outstanding.
- **Response:** `resp_valid`=1 for exactly the cycle after edge E+LAT, together with `resp_rdata` and `resp_exc`.
- **Next request:** `req_ready` returns to 1 in that same cycle, so back-to-back requests are accepted every LAT+1 cycles.
- **Store commit:** the array is written on edge E. A load accepted at E+LAT+1 or later sees the new data.
- **Store log:** `log_*` is registered at E, so `log_valid` is high for the single cycle following edge E.
- **Ignored inputs:** request inputs are ignored while `req_ready`=0. `req_valid` dropping without a handshake has no effect.
- **Output hold:** `resp_rdata`, `resp_exc` and `log_*` hold their last values when their valid is low. They are cleared only by reset.

## Test plan
1. **Reset and clear.**
   - Stimulus: DEPTH=16, LAT=1. Assert `reset` 3 cycles, then release.
   - Required: `init_done`=0 for 15 edges and 1 after the 16th; then a load word @0x3C returns 0.
2. **Store/load round trip.**
   - Stimulus: word store 0x12345678 @0x10; byte store 0xAB @0x11; load word @0x10.
   - Required: log pulses carry `log_data` 0x12345678 then 0x1234AB78; the load returns 0x1234AB78.
3. **Extension.**
   - Stimulus: memory word @0x20 = 0x8000_FF80.
   - Required:
     - `lb` @0x20 → 0xFFFF_FF80.
     - `lbu` @0x20 → 0x0000_0080.
     - `lh` @0x22 → 0xFFFF_8000.
     - `lhu` @0x20 → 0x0000_FF80.
4. **Exceptions.**
   - Stimulus: store half @0x13; store word @DEPTH*4; load with `size`=3; load word @0x0 with BASE_ADDR=0x1000.
   - Required: `resp_exc` = 1, 2, 1, 2 respectively; no log pulses; memory unchanged.
5. **Latency and ready.**
   - Stimulus: LAT=4, `req_valid` held high continuously.
   - Required: acceptances exactly 5 cycles apart; `resp_valid` high for one cycle, 4 cycles after each acceptance edge.
6. **Reset mid-operation.**
   - Stimulus: assert `reset` during WAIT of a load, and again at `clr_idx`=7.
   - Required: no `resp_valid` for the dropped load; `init_done` rises DEPTH edges after the final reset release.
